// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU (A) and memory (B) writebacks onto one register-file write port.
// Latency: a write handed over at edge N drives write_enable_o in the following cycle and commits at edge N+1.
// Backpressure: one holding slot per requester. x_ready_o = !slot_full || granted, so a requester granted every cycle streams at full rate.
//
// Ports:
//   clk_i, rst_n_i                    clock, asynchronous active-low reset
//   a_valid_i/a_dst_i/a_data_i        requester A write offer;   a_ready_o accepts it
//   b_valid_i/b_dst_i/b_data_i        requester B write offer;   b_ready_o accepts it
//   write_enable_o/reg_write_dst_o/write_data_o   register file write port (all zero when idle)
//   busy_o                            bit i set while a held write targets register i
//
// Optional build macro RF_WB_ARB_ZERO_DROP_EN:
//   when defined, writes to register 0 are accepted but silently dropped.

module rf_wb_arbiter (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        a_valid_i,
  input  logic [4:0]  a_dst_i,
  input  logic [31:0] a_data_i,
  output logic        a_ready_o,
  input  logic        b_valid_i,
  input  logic [4:0]  b_dst_i,
  input  logic [31:0] b_data_i,
  output logic        b_ready_o,
  output logic        write_enable_o,
  output logic [4:0]  reg_write_dst_o,
  output logic [31:0] write_data_o,
  output logic [31:0] busy_o
);

  // Slot state. tag = 1 marks a slot as the younger of two full slots.
  logic        a_full_q, a_full_d;
  logic [4:0]  a_dst_q, a_dst_d;
  logic [31:0] a_data_q, a_data_d;
  logic        a_tag_q, a_tag_d;
  logic        b_full_q, b_full_d;
  logic [4:0]  b_dst_q, b_dst_d;
  logic [31:0] b_data_q, b_data_d;
  logic        b_tag_q, b_tag_d;
  // 1 = B received the most recent grant.
  logic        last_b_q, last_b_d;

  logic grant_a, grant_b;
  logic keep_a, keep_b;
  logic load_a, load_b;
  logic stay_a, stay_b;

  // Arbitration
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full_q && b_full_q) begin
      if (a_dst_q != b_dst_q) begin
        // Round-robin: whoever was not granted last goes next.
        grant_a = last_b_q;
      end else begin
        // Same register: older slot first so the final value is the newest.
        // Equal tags means both arrived together; B is ordered first.
        grant_a = !a_tag_q && b_tag_q;
      end
      grant_b = !grant_a;
    end else begin
      grant_a = a_full_q;
      grant_b = b_full_q;
    end
  end

  assign a_ready_o = !a_full_q || grant_a;
  assign b_ready_o = !b_full_q || grant_b;

`ifdef RF_WB_ARB_ZERO_DROP_EN
  assign keep_a = (a_dst_i != 5'd0);
  assign keep_b = (b_dst_i != 5'd0);
`else
  assign keep_a = 1'b1;
  assign keep_b = 1'b1;
`endif

  assign load_a = a_valid_i && a_ready_o && keep_a;
  assign load_b = b_valid_i && b_ready_o && keep_b;
  // A full slot that is not granted cannot be reloaded (its ready is low).
  assign stay_a = a_full_q && !grant_a;
  assign stay_b = b_full_q && !grant_b;

  // Next-state
  always_comb begin
    a_full_d = load_a || stay_a;
    b_full_d = load_b || stay_b;
    a_dst_d  = load_a ? a_dst_i  : a_dst_q;
    a_data_d = load_a ? a_data_i : a_data_q;
    b_dst_d  = load_b ? b_dst_i  : b_dst_q;
    b_data_d = load_b ? b_data_i : b_data_q;
    // A newly loaded slot is younger only if the other slot stays occupied
    // by an older write; a surviving slot becomes the older one whenever
    // its partner is freshly loaded.
    a_tag_d  = load_a ? stay_b : (load_b ? 1'b0 : a_tag_q);
    b_tag_d  = load_b ? stay_a : (load_a ? 1'b0 : b_tag_q);
    last_b_d = grant_b ? 1'b1 : (grant_a ? 1'b0 : last_b_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_full_q <= 1'b0;
      a_dst_q  <= 5'd0;
      a_data_q <= 32'd0;
      a_tag_q  <= 1'b0;
      b_full_q <= 1'b0;
      b_dst_q  <= 5'd0;
      b_data_q <= 32'd0;
      b_tag_q  <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      a_full_q <= a_full_d;
      a_dst_q  <= a_dst_d;
      a_data_q <= a_data_d;
      a_tag_q  <= a_tag_d;
      b_full_q <= b_full_d;
      b_dst_q  <= b_dst_d;
      b_data_q <= b_data_d;
      b_tag_q  <= b_tag_d;
      last_b_q <= last_b_d;
    end
  end

  // Register file port and hazard vector
  always_comb begin
    write_enable_o  = grant_a || grant_b;
    reg_write_dst_o = 5'd0;
    write_data_o    = 32'd0;
    if (grant_a) begin
      reg_write_dst_o = a_dst_q;
      write_data_o    = a_data_q;
    end else if (grant_b) begin
      reg_write_dst_o = b_dst_q;
      write_data_o    = b_data_q;
    end
    busy_o = 32'd0;
    if (a_full_q) busy_o = busy_o | (32'd1 << a_dst_q);
    if (b_full_q) busy_o = busy_o | (32'd1 << b_dst_q);
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic [4:0]  a_dst, b_dst;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        we;
  logic [4:0]  wdst;
  logic [31:0] wdata;
  logic [31:0] busy;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .a_valid_i      (a_valid),
    .a_dst_i        (a_dst),
    .a_data_i       (a_data),
    .a_ready_o      (a_ready),
    .b_valid_i      (b_valid),
    .b_dst_i        (b_dst),
    .b_data_i       (b_data),
    .b_ready_o      (b_ready),
    .write_enable_o (we),
    .reg_write_dst_o(wdst),
    .write_data_o   (wdata),
    .busy_o         (busy)
  );

`ifdef RF_WB_ARB_ZERO_DROP_EN
  localparam bit DROP0 = 1'b1;
`else
  localparam bit DROP0 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] rf_obs [32];

  typedef struct {
    bit          rst;
    bit          av;
    logic [4:0]  ad;
    logic [31:0] adat;
    bit          bv;
    logic [4:0]  bd;
    logic [31:0] bdat;
    bit          ewe;
    logic [4:0]  edst;
    logic [31:0] edat;
    logic [31:0] ebusy;
    bit          eard;
    bit          ebrd;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(bit rst, bit av, logic [4:0] ad, logic [31:0] adat,
                              bit bv, logic [4:0] bd, logic [31:0] bdat,
                              bit ewe, logic [4:0] edst, logic [31:0] edat,
                              logic [31:0] ebusy, bit eard, bit ebrd);
    vec_t v;
    v.rst = rst; v.av = av; v.ad = ad; v.adat = adat;
    v.bv = bv; v.bd = bd; v.bdat = bdat;
    v.ewe = ewe; v.edst = edst; v.edat = edat; v.ebusy = ebusy;
    v.eard = eard; v.ebrd = ebrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 0; b_valid = 0;
    a_dst = 0; b_dst = 0; a_data = 0; b_data = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input bit ewe, input logic [4:0] edst,
                               input logic [31:0] edat, input logic [31:0] ebusy,
                               input bit eard, input bit ebrd);
    chk({tag, ".we"},    {31'd0, we},      {31'd0, ewe});
    chk({tag, ".dst"},   {27'd0, wdst},    {27'd0, edst});
    chk({tag, ".data"},  wdata,            edat);
    chk({tag, ".busy"},  busy,             ebusy);
    chk({tag, ".a_rdy"}, {31'd0, a_ready}, {31'd0, eard});
    chk({tag, ".b_rdy"}, {31'd0, b_ready}, {31'd0, ebrd});
  endtask

  // Reference model: pending writes with integer arrival stamps.
  bit          m_full [2];
  logic [4:0]  m_dst  [2];
  logic [31:0] m_data [2];
  int          m_seq  [2];
  bit          m_last_b;
  int          m_cyc;

  function automatic int model_grant();
    if (m_full[0] && m_full[1]) begin
      if (m_dst[0] != m_dst[1]) return m_last_b ? 0 : 1;
      return (m_seq[0] < m_seq[1]) ? 0 : 1;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  initial begin
    bit          pend [2];
    logic [4:0]  pdst [2];
    logic [31:0] pdat [2];

    for (int i = 0; i < 32; i++) rf_obs[i] = 32'hDEAD_BEEF;

    // Directed vectors, each applied for one cycle.
    tbl[0]  = mk(1, 0,0,0,            0,0,0,            0,0,0,            0,        1,1);
    tbl[1]  = mk(0, 1,5,32'h1234,     0,0,0,            0,0,0,            0,        1,1);
    tbl[2]  = mk(0, 0,0,0,            0,0,0,            1,5,32'h1234,     32'h20,   1,1);
    tbl[3]  = mk(0, 0,0,0,            0,0,0,            0,0,0,            0,        1,1);
    tbl[4]  = mk(1, 1,3,32'hA0,       1,7,32'hB0,       0,0,0,            0,        1,1);
    tbl[5]  = mk(0, 1,3,32'hA1,       1,7,32'hB1,       1,3,32'hA0,       32'h88,   1,0);
    tbl[6]  = mk(0, 1,3,32'hA2,       1,7,32'hB1,       1,7,32'hB0,       32'h88,   0,1);
    tbl[7]  = mk(0, 1,3,32'hA2,       1,7,32'hB2,       1,3,32'hA1,       32'h88,   1,0);
    tbl[8]  = mk(0, 0,0,0,            1,7,32'hB2,       1,7,32'hB1,       32'h88,   0,1);
    tbl[9]  = mk(0, 0,0,0,            0,0,0,            1,3,32'hA2,       32'h88,   1,0);
    tbl[10] = mk(0, 0,0,0,            0,0,0,            1,7,32'hB2,       32'h80,   1,1);
    tbl[11] = mk(0, 0,0,0,            0,0,0,            0,0,0,            0,        1,1);
    tbl[12] = mk(1, 1,9,32'h1,        1,9,32'h2,        0,0,0,            0,        1,1);
    tbl[13] = mk(0, 0,0,0,            0,0,0,            1,9,32'h2,        32'h200,  0,1);
    tbl[14] = mk(0, 0,0,0,            0,0,0,            1,9,32'h1,        32'h200,  1,1);
    tbl[15] = mk(0, 0,0,0,            0,0,0,            0,0,0,            0,        1,1);
    tbl[16] = mk(1, 1,0,32'hFFFF,     0,0,0,            0,0,0,            0,        1,1);
    if (DROP0)
      tbl[17] = mk(0, 0,0,0,          0,0,0,            0,0,0,            0,        1,1);
    else
      tbl[17] = mk(0, 0,0,0,          0,0,0,            1,0,32'hFFFF,     32'h1,    1,1);

    do_reset();
    #3 check_outputs("reset_idle", 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rst) do_reset();
      a_valid = tbl[i].av; a_dst = tbl[i].ad; a_data = tbl[i].adat;
      b_valid = tbl[i].bv; b_dst = tbl[i].bd; b_data = tbl[i].bdat;
      #3;
      check_outputs($sformatf("vec%0d", i), tbl[i].ewe, tbl[i].edst, tbl[i].edat,
                    tbl[i].ebusy, tbl[i].eard, tbl[i].ebrd);
      if (we) rf_obs[wdst] = wdata;
      @(posedge clk); #1;
    end
    a_valid = 0; b_valid = 0;
    chk("same_dst_final_r9", rf_obs[9], 32'h1);

    // Reset asserted while B holds a write to register 4.
    do_reset();
    b_valid = 1; b_dst = 4; b_data = 32'h44;
    @(posedge clk); #1;
    b_valid = 0;
    #1 chk("held_r4_we",   {31'd0, we}, 32'd1);
    chk("held_r4_busy", busy, 32'h10);
    #1 rst_n = 1'b0;
    #1 check_outputs("rst_mid", 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    #2 check_outputs("rst_after", 0, 0, 0, 0, 1, 1);
    chk("r4_never_written", rf_obs[4], 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      m_full[r] = 0; m_dst[r] = 0; m_data[r] = 0; m_seq[r] = 0; pend[r] = 0;
      pdst[r] = 0; pdat[r] = 0;
    end
    m_last_b = 1;
    m_cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      int g;
      bit rdy [2];
      bit kw;
      logic [4:0]  edst;
      logic [31:0] edat, ebusy;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) != 0) begin
          pend[r] = 1;
          pdst[r] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
          pdat[r] = $urandom;
        end
      end
      a_valid = pend[0]; a_dst = pdst[0]; a_data = pdat[0];
      b_valid = pend[1]; b_dst = pdst[1]; b_data = pdat[1];

      g = model_grant();
      for (int r = 0; r < 2; r++) rdy[r] = !m_full[r] || (g == r);
      edst = (g >= 0) ? m_dst[g] : 5'd0;
      edat = (g >= 0) ? m_data[g] : 32'd0;
      ebusy = 0;
      for (int r = 0; r < 2; r++) if (m_full[r]) ebusy[m_dst[r]] = 1'b1;
      #3;
      check_outputs("rand", g >= 0, edst, edat, ebusy, rdy[0], rdy[1]);

      @(posedge clk);
      m_cyc++;
      if (g >= 0) begin
        m_full[g] = 0;
        m_last_b = (g == 1);
      end
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && rdy[r]) begin
          pend[r] = 0;
          kw = !(DROP0 && pdst[r] == 5'd0);
          if (kw) begin
            m_full[r] = 1; m_dst[r] = pdst[r]; m_data[r] = pdat[r]; m_seq[r] = m_cyc;
          end
        end
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
